// File: rtl/pwm_edge_pkg.sv
// Shared definitions for the PWM edge calculator.
//   - PWM_WIDTH : default time/duty/phase width. The shadow buffer entry type is
//                 sized from it, so the top-level WIDTH must equal it.
//   - PIPE_LAT  : depth of the arithmetic pipeline in cycles.
//   - pwm_state_e : frame FSM states.
//   - edge_pair_t : one channel's {rise, fall} pair as held in the shadow buffer.
package pwm_edge_pkg;

  localparam int unsigned PWM_WIDTH = 13;
  localparam int unsigned PIPE_LAT  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StPending
  } pwm_state_e;

  typedef struct packed {
    logic [PWM_WIDTH-1:0] rise;
    logic [PWM_WIDTH-1:0] fall;
  } edge_pair_t;

endpackage

// File: rtl/pwm_edge_arith.sv
// Single-channel 3-stage pipeline: (duty, phase) -> (rise, fall) modulo cycle.
// Results appear on valid_o exactly three cycles after valid_i.
// Optional macro PWM_EDGE_CALC_DUTY_LIMIT_EN adds duty_limit_i, which further caps
// the effective duty and is sampled together with the beat.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   valid_i           beat valid
//   duty_i, phase_i   on-time and pulse-centre time (phase < 2*cycle)
//   cycle_i           PWM period in ticks (static)
//   duty_limit_i      optional duty cap
//   valid_o           result valid
//   rise_o, fall_o    edge times; full duty gives rise=0, fall=cycle
module pwm_edge_arith #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] phase_i,
  input  logic [WIDTH-1:0] cycle_i,
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
  input  logic [WIDTH-1:0] duty_limit_i,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Stage 1: fold phase into [0, cycle), clamp duty.
  logic [WIDTH-1:0] p1_d, d1_d, p1_q, d1_q;
  logic             v1_q;

  always_comb begin
    p1_d = (phase_i >= cycle_i) ? phase_i - cycle_i : phase_i;
    d1_d = (duty_i < cycle_i) ? duty_i : cycle_i;
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
    if (duty_limit_i < d1_d) d1_d = duty_limit_i;
`endif
  end

  // Stage 2: split duty around the centre; r is held in WIDTH+1 bits so its MSB is the sign.
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH:0]   r2_d, f2_d, r2_q, f2_q;
  logic             full2_d, full2_q, v2_q;

  always_comb begin
    lo      = d1_q >> 1;
    hi      = d1_q - lo;
    r2_d    = {1'b0, p1_q} - {1'b0, lo};
    f2_d    = {1'b0, p1_q} + {1'b0, hi};
    full2_d = (d1_q == cycle_i);
  end

  // Stage 3: wrap both edges back into [0, cycle).
  logic [WIDTH-1:0] r3_d, f3_d, r3_q, f3_q;
  logic             v3_q;

  always_comb begin
    if (full2_q) begin
      // Always on for a downstream rise <= t < fall compare.
      r3_d = '0;
      f3_d = cycle_i;
    end else begin
      r3_d = r2_q[WIDTH] ? WIDTH'(r2_q + {1'b0, cycle_i}) : r2_q[WIDTH-1:0];
      f3_d = (f2_q >= {1'b0, cycle_i}) ? WIDTH'(f2_q - {1'b0, cycle_i}) : f2_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p1_q    <= '0;
      d1_q    <= '0;
      r2_q    <= '0;
      f2_q    <= '0;
      full2_q <= 1'b0;
      r3_q    <= '0;
      f3_q    <= '0;
    end else begin
      v1_q    <= valid_i;
      p1_q    <= p1_d;
      d1_q    <= d1_d;
      v2_q    <= v1_q;
      r2_q    <= r2_d;
      f2_q    <= f2_d;
      full2_q <= full2_d;
      v3_q    <= v2_q;
      r3_q    <= r3_d;
      f3_q    <= f3_d;
    end
  end

  assign valid_o = v3_q;
  assign rise_o  = r3_q;
  assign fall_o  = f3_q;

endmodule

// File: rtl/pwm_edge_calc.sv
// PWM edge calculator: accepts one (duty, phase) beat per channel, computes edge times
// through pwm_edge_arith into a shadow buffer, and commits the whole frame to rise_o /
// fall_o on the edge after time_cnt_i == cycle_i-1, so generators never see a torn frame.
// Optional macro PWM_EDGE_CALC_DUTY_LIMIT_EN adds the duty_limit_i input.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cycle_i             PWM period (>= 2, static during a frame)
//   time_cnt_i          free-running period counter 0..cycle-1
//   din_valid_i/ready_o beat handshake (ready only while collecting a frame)
//   duty_i, phase_i     beat payload
//   duty_limit_i        optional duty cap
//   rise_o, fall_o      committed edges, channel i at [i*WIDTH +: WIDTH]
//   update_o            one-cycle pulse when rise_o/fall_o change
module pwm_edge_calc
  import pwm_edge_pkg::*;
#(
  parameter int unsigned WIDTH  = PWM_WIDTH,  // must equal PWM_WIDTH (shadow entry type)
  parameter int unsigned NUM_CH = 249
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH-1:0]        cycle_i,
  input  logic [WIDTH-1:0]        time_cnt_i,
  input  logic                    din_valid_i,
  output logic                    din_ready_o,
  input  logic [WIDTH-1:0]        duty_i,
  input  logic [WIDTH-1:0]        phase_i,
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
  input  logic [WIDTH-1:0]        duty_limit_i,
`endif
  output logic [NUM_CH*WIDTH-1:0] rise_o,
  output logic [NUM_CH*WIDTH-1:0] fall_o,
  output logic                    update_o
);

  localparam int unsigned     IdxW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_CH - 1);
  localparam logic [1:0]      DrainLast = 2'(PIPE_LAT - 1);

  pwm_state_e              state_q;
  logic [IdxW-1:0]         in_idx_q;
  logic [IdxW-1:0]         wr_idx_q;
  logic [1:0]              drain_q;
  edge_pair_t              shadow_q [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] rise_q, fall_q;
  logic                    update_q;

  logic                    beat;
  logic                    arith_valid;
  logic [WIDTH-1:0]        arith_rise, arith_fall;

  // Gated by reset so ready reads 0 while reset is held.
  assign din_ready_o = !rst_i && ((state_q == StIdle) || (state_q == StLoad));
  assign beat        = din_valid_i && din_ready_o;

  pwm_edge_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (beat),
    .duty_i       (duty_i),
    .phase_i      (phase_i),
    .cycle_i      (cycle_i),
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
    .duty_limit_i (duty_limit_i),
`endif
    .valid_o      (arith_valid),
    .rise_o       (arith_rise),
    .fall_o       (arith_fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      in_idx_q <= '0;
      wr_idx_q <= '0;
      drain_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      update_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      update_q <= 1'b0;

      // Results leave the pipeline in beat order, so a plain counter addresses the shadow.
      if (arith_valid) begin
        shadow_q[wr_idx_q] <= '{rise: arith_rise, fall: arith_fall};
        wr_idx_q           <= wr_idx_q + 1'b1;
      end

      unique case (state_q)
        StIdle, StLoad: begin
          if (beat) begin
            if (in_idx_q == LastIdx) begin
              in_idx_q <= '0;
              drain_q  <= '0;
              state_q  <= StDrain;
            end else begin
              in_idx_q <= in_idx_q + 1'b1;
              state_q  <= StLoad;
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DrainLast) state_q <= StPending;
        end
        StPending: begin
          if (time_cnt_i == cycle_i - 1'b1) begin
            for (int i = 0; i < NUM_CH; i++) begin
              rise_q[i*WIDTH +: WIDTH] <= shadow_q[i].rise;
              fall_q[i*WIDTH +: WIDTH] <= shadow_q[i].fall;
            end
            update_q <= 1'b1;
            wr_idx_q <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign update_o = update_q;

endmodule

// File: tb/tb_pwm_edge_calc.sv
// Self-checking bench for pwm_edge_calc (WIDTH=13, NUM_CH=4, CYCLE=4096).
// Expected edge pairs are pushed to a scoreboard queue as each frame is driven and
// popped when the DUT pulses update.
module tb_pwm_edge_calc;

  localparam int W   = 13;
  localparam int NCH = 4;
  localparam int CYC = 4096;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   cycle = W'(CYC);
  logic [W-1:0]   time_cnt = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [W-1:0]   duty = '0;
  logic [W-1:0]   phase = '0;
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
  logic [W-1:0]   duty_limit = '1;
`endif
  logic [NCH*W-1:0] rise, fall;
  logic             update;

  int n_total = 0;
  int n_pass  = 0;
  int upd_cnt = 0;
  int lim_now = 8191;
  int fr_duty [NCH];
  int fr_phase[NCH];
  logic [2*W-1:0] exp_q[$];

  pwm_edge_calc #(
    .WIDTH  (W),
    .NUM_CH (NCH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cycle_i      (cycle),
    .time_cnt_i   (time_cnt),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .duty_i       (duty),
    .phase_i      (phase),
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
    .duty_limit_i (duty_limit),
`endif
    .rise_o       (rise),
    .fall_o       (fall),
    .update_o     (update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) time_cnt <= (time_cnt == cycle - 1'b1) ? '0 : time_cnt + 1'b1;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  // Reference edge computation straight from the arithmetic description.
  function automatic logic [2*W-1:0] model(input int d_in, input int ph, input int lim);
    int p, d, r, f;
    p = (ph >= CYC) ? ph - CYC : ph;
    d = (d_in < CYC) ? d_in : CYC;
    if (lim < d) d = lim;
    if (d == CYC) begin
      r = 0;
      f = CYC;
    end else begin
      r = p - d / 2;
      f = p + (d - d / 2);
      if (r < 0) r += CYC;
      if (f >= CYC) f -= CYC;
    end
    return {W'(r), W'(f)};
  endfunction

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input int d, input int p);
    int n;
    n = 0;
    din_valid = 1'b1;
    duty      = W'(d);
    phase     = W'(p);
    while (din_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      n_total++;
      $display("FAIL beat_accept_timeout ready=%b required=1", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit push);
    for (int i = 0; i < NCH; i++) begin
      if (push) exp_q.push_back(model(fr_duty[i], fr_phase[i], lim_now));
      send_beat(fr_duty[i], fr_phase[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  // Waits for the commit pulse; reports whether outputs held until then, the counter
  // value seen with the pulse and whether the pulse lasted exactly one cycle.
  task automatic wait_update(output bit ok, output bit held, output int tc_at,
                             output bit pulse_ok);
    logic [NCH*W-1:0] r0, f0;
    int n;
    r0 = rise;
    f0 = fall;
    held = 1'b1;
    n = 0;
    while (update !== 1'b1 && n < 2 * CYC + 64) begin
      if (rise !== r0 || fall !== f0) held = 1'b0;
      @(negedge clk);
      n++;
    end
    ok = (update === 1'b1);
    tc_at = int'(time_cnt);
    @(negedge clk);
    pulse_ok = (update === 1'b0);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++;
    if (din_ready !== 1'b0 || update !== 1'b0) begin
      $display("FAIL reset_ctrl ready=%b update=%b required 0 0", din_ready, update);
    end else n_pass++;
    n_total++;
    if (rise !== '0 || fall !== '0) begin
      $display("FAIL reset_edges rise=%h fall=%h required 0", rise, fall);
    end else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (din_ready !== 1'b1) $display("FAIL reset_release ready=%b required 1", din_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_frame;
    bit ok, held, pulse_ok;
    int tc_at;
    logic [2*W-1:0] e;
    int exp_r[NCH] = '{1024, 3596, 7, 100};
    int exp_f[NCH] = '{3072, 500, 14, 100};
    fr_duty  = '{2048, 1000, 7, 0};
    fr_phase = '{2048, 0, 10, 100};
    for (int i = 0; i < NCH; i++) exp_q.push_back({W'(exp_r[i]), W'(exp_f[i])});
    send_frame(0, 1'b0);
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL frame_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL frame_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_full_duty;
    bit ok, held, pulse_ok, all_on;
    int tc_at, r0, f0;
    logic [2*W-1:0] e;
    fr_duty  = '{5000, 100, 4096, 1};
    fr_phase = '{4200, 4100, 0, 4095};
    send_frame(0, 1'b1);
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL full_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL full_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
    // Downstream rise <= t < fall compare must be on for every tick of the period.
    r0 = int'(rise[0 +: W]);
    f0 = int'(fall[0 +: W]);
    all_on = 1'b1;
    for (int t = 0; t < CYC; t++) if (!(t >= r0 && t < f0)) all_on = 1'b0;
    n_total++;
    if (!all_on) $display("FAIL full_always_on r=%0d f=%0d required r=0 f=4096", r0, f0);
    else n_pass++;
  endtask

  task automatic test_hold;
    bit ok, held, pulse_ok, ready_low;
    int tc_at, n;
    logic [2*W-1:0] e;
    fr_duty  = '{300, 8191, 50, 4095};
    fr_phase = '{4000, 8000, 25, 4095};
    n = 0;
    while (time_cnt != W'(2) && n < 2 * CYC) begin
      @(negedge clk);
      n++;
    end
    send_frame(0, 1'b1);
    // Now draining: ready must stay low and stray beats must not reach the frame.
    ready_low = 1'b1;
    din_valid = 1'b1;
    duty      = W'(1234);
    phase     = W'(77);
    repeat (8) begin
      if (din_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    n_total++;
    if (!ready_low || time_cnt >= W'(CYC - 1))
      $display("FAIL hold_ready_low ready_low=%0b tc=%0d required 1 and tc<4095",
               ready_low, time_cnt);
    else n_pass++;
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL hold_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL hold_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok, held, pulse_ok;
    int tc_at;
    logic [2*W-1:0] e;
    send_beat(999, 111);
    send_beat(888, 222);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (rise !== '0 || fall !== '0 || din_ready !== 1'b1 || update !== 1'b0)
      $display("FAIL mid_reset rise=%h fall=%h ready=%b upd=%b required 0 0 1 0",
               rise, fall, din_ready, update);
    else n_pass++;
    @(negedge clk);
    fr_duty  = '{10, 20, 4095, 2};
    fr_phase = '{20, 4090, 4095, 1};
    send_frame(0, 1'b1);
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL mid_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL mid_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    bit ok, held, pulse_ok;
    int tc_at, upd0;
    logic [2*W-1:0] e;
    int exp_r[NCH] = '{1024, 3596, 7, 100};
    int exp_f[NCH] = '{3072, 500, 14, 100};
    fr_duty  = '{2048, 1000, 7, 0};
    fr_phase = '{2048, 0, 10, 100};
    upd0 = upd_cnt;
    for (int i = 0; i < NCH; i++) exp_q.push_back({W'(exp_r[i]), W'(exp_f[i])});
    send_frame(1, 1'b0);
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL b2b_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL b2b_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
    repeat (20) @(negedge clk);
    n_total++;
    if (upd_cnt - upd0 != 1) $display("FAIL b2b_update_count got=%0d required=1", upd_cnt - upd0);
    else n_pass++;
  endtask

`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
  task automatic test_duty_limit;
    bit ok, held, pulse_ok;
    int tc_at;
    logic [2*W-1:0] e;
    lim_now    = 1000;
    duty_limit = W'(lim_now);
    fr_duty    = '{3000, 500, 4096, 0};
    fr_phase   = '{2000, 100, 0, 5000};
    send_frame(0, 1'b1);
    wait_update(ok, held, tc_at, pulse_ok);
    n_total++;
    if (!ok || !held || tc_at != 0 || !pulse_ok)
      $display("FAIL limit_commit ok=%0b held=%0b tc=%0d pulse=%0b required 1 1 0 1",
               ok, held, tc_at, pulse_ok);
    else n_pass++;
    n_total++;
    if (rise[0 +: W] !== W'(1500) || fall[0 +: W] !== W'(2500))
      $display("FAIL limit_ch0_const got r=%0d f=%0d required r=1500 f=2500",
               rise[0 +: W], fall[0 +: W]);
    else n_pass++;
    for (int i = 0; i < NCH; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_total++;
      if (rise[i*W +: W] !== e[2*W-1:W] || fall[i*W +: W] !== e[W-1:0])
        $display("FAIL limit_ch%0d got r=%0d f=%0d required r=%0d f=%0d", i,
                 rise[i*W +: W], fall[i*W +: W], e[2*W-1:W], e[W-1:0]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_frame;
    test_full_duty;
    test_hold;
    test_reset_mid;
    test_back_to_back;
`ifdef PWM_EDGE_CALC_DUTY_LIMIT_EN
    test_duty_limit;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
